pipe_skid_buffer: RTL and testbench

//  Two-entry elastic pipeline stage: consumer-side counterpart of enable-gated pipeline registers.

---
 rtl/pipe_skid_buffer.sv | 75 +++++++
 tb/tb_pipe_skid_buffer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry elastic valid/ready stage with registered ready; optional flush via PIPE_SKID_FLUSH_EN
module pipe_skid_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
`ifdef PIPE_SKID_FLUSH_EN
   input  logic             flush,
`endif
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       count
);
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;
   logic [1:0]       state, state_d;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             in_fire, out_fire, kill;
   logic             load_main, load_skid, main_from_skid;
`ifdef PIPE_SKID_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif
   assign in_ready  = state != FULL;
   assign out_valid = state != EMPTY;
   assign count     = state == FULL ? 2'd2 : state == BUSY ? 2'd1 : 2'd0;
   assign out_data  = main_q;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   // next occupancy and which storage slot captures this cycle; flush wins over any fire
   always_comb begin
      state_d        = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            state_d   = in_fire ? BUSY : EMPTY;
            load_main = in_fire;
         end
         BUSY: begin
            state_d   = in_fire ? (out_fire ? BUSY : FULL) : (out_fire ? EMPTY : BUSY);
            load_main = in_fire & out_fire;
            load_skid = in_fire & ~out_fire;
         end
         FULL: begin
            state_d        = out_fire ? BUSY : FULL;
            main_from_skid = out_fire;
         end
         default: state_d = EMPTY;
      endcase
      if (kill) begin
         state_d        = EMPTY;
         load_main      = 1'b0;
         load_skid      = 1'b0;
         main_from_skid = 1'b0;
      end
   end
   // occupancy state, cleared asynchronously so held words vanish at once on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_d;
   end
   // payload storage needs no reset: it is only observed while out_valid is high
   always_ff @(posedge clk) begin
      main_q <= load_main ? in_data : main_from_skid ? skid_q : main_q;
      skid_q <= load_skid ? in_data : skid_q;
   end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb_pipe_skid_buffer: randomized and directed checks of pipe_skid_buffer against a queue model
module tb_pipe_skid_buffer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [1:0]  count;
   int          tests = 0;
   int          failed = 0;
   logic [31:0] mq[$];

   pipe_skid_buffer #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
`ifdef PIPE_SKID_FLUSH_EN
      .flush(flush),
`endif
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   // advance one clock and update the two-slot FIFO model from the handshake rules
   task automatic tick();
      bit inf, outf;
      logic [31:0] d;
      inf  = in_valid && (mq.size() < 2);
      outf = out_ready && (mq.size() > 0);
      d    = in_data;
      @(posedge clk);
      #1;
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back(d);
      if (flush) mq.delete();
   endtask

   task automatic test_reset();
      tests++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_init: valid=%b count=%0d ready=%b expected 0/0/1", out_valid, count, in_ready);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hDEAD0001;
      tick();
      in_data = 32'hDEAD0002;
      tick();
      in_valid = 1'b0;
      tests++;
      if (count !== 2'd2 || in_ready !== 1'b0) begin
         failed++;
         $display("FAIL reset_fill: count=%0d ready=%b expected 2/0", count, in_ready);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL reset_midfull: valid=%b count=%0d ready=%b expected 0/0/1", out_valid, count, in_ready);
      end
      #2 reset = 1'b0;
      mq.delete();
      tick();
      tests++;
      if (out_valid !== 1'b0 || count !== 2'd0) begin
         failed++;
         $display("FAIL reset_after: valid=%b count=%0d expected 0/0", out_valid, count);
      end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data = 32'(i + 1);
         tests++;
         if (in_ready !== 1'b1) begin
            failed++;
            $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
         end
         tick();
         tests++;
         if (out_valid !== 1'b1 || out_data !== 32'(i + 1) || count !== 2'd1) begin
            failed++;
            $display("FAIL stream_out[%0d]: valid=%b data=%h count=%0d expected 1/%h/1", i, out_valid, out_data, count, 32'(i + 1));
         end
      end
      in_valid = 1'b0;
      tick();
      tests++;
      if (out_valid !== 1'b0 || count !== 2'd0 || mq.size() != 0) begin
         failed++;
         $display("FAIL stream_drain: valid=%b count=%0d expected 0/0", out_valid, count);
      end
   endtask

   task automatic test_stall_fill();
      logic [31:0] exp_w[3];
      logic [31:0] got[$];
      bit acc;
      exp_w[0] = 32'hA;
      exp_w[1] = 32'hB;
      exp_w[2] = 32'hC;
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = exp_w[0];
      tick();
      in_data = exp_w[1];
      tick();
      in_data = exp_w[2];
      tick();
      tick();
      tests++;
      if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== exp_w[0] || out_valid !== 1'b1) begin
         failed++;
         $display("FAIL stall_full: count=%0d ready=%b data=%h expected 2/0/%h", count, in_ready, out_data, exp_w[0]);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 8 && got.size() < 3; c++) begin
         if (out_valid && out_ready) got.push_back(out_data);
         acc = in_valid && in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      tests++;
      if (got.size() != 3) begin
         failed++;
         $display("FAIL stall_count: got %0d words expected 3", got.size());
      end
      for (int i = 0; i < 3 && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_w[i]) begin
            failed++;
            $display("FAIL stall_order[%0d]: got %h expected %h", i, got[i], exp_w[i]);
         end
      end
      in_valid = 1'b0;
      tick();
      tick();
      tests++;
      if (count !== 2'd0) begin
         failed++;
         $display("FAIL stall_empty: count=%0d expected 0", count);
      end
   endtask

   task automatic test_simultaneous();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h11;
      tick();
      tests++;
      if (out_data !== 32'h11 || count !== 2'd1) begin
         failed++;
         $display("FAIL simul_load: data=%h count=%0d expected 11/1", out_data, count);
      end
      in_data = 32'h22;
      out_ready = 1'b1;
      tick();
      tests++;
      if (out_data !== 32'h22 || count !== 2'd1 || out_valid !== 1'b1) begin
         failed++;
         $display("FAIL simul_swap: data=%h count=%0d expected 22/1", out_data, count);
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_random();
      int errs = 0;
      bit acc, stall;
      logic [31:0] prev;
      in_valid = 1'b0;
      for (int c = 0; c < 10000 && errs < 8; c++) begin
         if (!in_valid || acc) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
         end
         out_ready = 1'($urandom_range(0, 3) != 0 ? $urandom_range(0, 1) : 0);
         acc = in_valid && in_ready;
         stall = out_valid && !out_ready;
         prev = out_data;
         tick();
         tests++;
         if (out_valid !== (mq.size() > 0) || count !== 2'(mq.size()) || in_ready !== (mq.size() < 2)
             || (mq.size() > 0 && out_data !== mq[0])) begin
            failed++;
            errs++;
            $display("FAIL random[%0d]: valid=%b count=%0d ready=%b data=%h expected count=%0d data=%h",
                     c, out_valid, count, in_ready, out_data, mq.size(), mq.size() > 0 ? mq[0] : 32'h0);
         end
         if (stall) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== prev) begin
               failed++;
               errs++;
               $display("FAIL random_stable[%0d]: valid=%b data=%h expected 1/%h", c, out_valid, out_data, prev);
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
   endtask

`ifdef PIPE_SKID_FLUSH_EN
   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 32'h44;
      tick();
      in_data = 32'h55;
      tick();
      tests++;
      if (count !== 2'd2) begin
         failed++;
         $display("FAIL flush_fill: count=%0d expected 2", count);
      end
      in_data = 32'h33;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      tests++;
      if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failed++;
         $display("FAIL flush_clear: count=%0d valid=%b ready=%b expected 0/0/1", count, out_valid, in_ready);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests++;
         if (out_valid !== 1'b0) begin
            failed++;
            $display("FAIL flush_leak[%0d]: valid=%b data=%h expected no output", c, out_valid, out_data);
         end
      end
   endtask
`endif

   initial begin
      #12;
      test_reset();
      test_streaming();
      test_stall_fill();
      test_simultaneous();
      test_random();
`ifdef PIPE_SKID_FLUSH_EN
      test_flush();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
